// File: rtl/conf_regs_launcher.sv
// conf_regs_launcher
//   OBI master that sequences one e-GPU kernel launch over the conf_regs port.
//   An accepted start writes KERNEL_ADDR (0x0C), ARG0..ARG2 (0x10/0x14/0x18)
//   and START=1 (0x1C), in that order. It then polls STATUS (0x20) until it
//   reads 32'h1, with an optional abort after TIMEOUT cycles of polling.
//
// Parameters
//   BASE_ADDR : base added to every register offset
//   POLL_GAP  : idle cycles between a poll response and the next poll request
//   TIMEOUT   : max cycles in the poll phase before abort (0 = never)
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : launch request, sampled only while idle
//   kernel_addr_i, arg*_i   : launch operands, latched on an accepted start
//   req_o/we_o/be_o/addr_o/wdata_o, gnt_i/rvalid_i/rdata_i : OBI master port
//   busy_o                  : high from accepted start until DONE/ABORT exits
//   done_o                  : 1-cycle pulse, STATUS read back as 32'h1
//   timeout_o               : 1-cycle pulse, poll phase timed out
module conf_regs_launcher #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned POLL_GAP  = 8,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] kernel_addr_i,
  input  logic [31:0] arg0_i,
  input  logic [31:0] arg1_i,
  input  logic [31:0] arg2_i,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RSP, S_POLL_REQ, S_POLL_RSP, S_POLL_WAIT, S_DONE, S_ABORT
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] tcnt;
  logic [31:0] gap;
  logic [31:0] kaddr_q, arg0_q, arg1_q, arg2_q;
  logic        timed_out;

  assign be_o = 4'b1111;

  // The counter keeps running while a read is in flight, so it may already be
  // past TIMEOUT when the response lands; >= lets that response trigger abort.
  assign timed_out = (TIMEOUT != 0) && (tcnt >= TIMEOUT);

  function automatic logic [31:0] wr_addr(input logic [2:0] i);
    case (i)
      3'd0:    wr_addr = BASE_ADDR + 32'h0C;
      3'd1:    wr_addr = BASE_ADDR + 32'h10;
      3'd2:    wr_addr = BASE_ADDR + 32'h14;
      3'd3:    wr_addr = BASE_ADDR + 32'h18;
      default: wr_addr = BASE_ADDR + 32'h1C;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] i);
    case (i)
      3'd0:    wr_data = kaddr_q;
      3'd1:    wr_data = arg0_q;
      3'd2:    wr_data = arg1_q;
      3'd3:    wr_data = arg2_q;
      default: wr_data = 32'h1;
    endcase
  endfunction

  // Launch operands: plain data registers, captured only on an accepted start.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && start_i) begin
      kaddr_q <= kernel_addr_i;
      arg0_q  <= arg0_i;
      arg1_q  <= arg1_i;
      arg2_q  <= arg2_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      req_o     <= 1'b0;
      we_o      <= 1'b0;
      addr_o    <= 32'h0;
      wdata_o   <= 32'h0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      idx       <= 3'd0;
      tcnt      <= 32'h0;
      gap       <= 32'h0;
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      if (state == S_POLL_REQ || state == S_POLL_RSP || state == S_POLL_WAIT)
        tcnt <= tcnt + 32'h1;

      case (state)
        S_IDLE: begin
          if (start_i) begin
            // First write is issued straight from the inputs since the
            // operand registers load on this same edge.
            idx     <= 3'd0;
            busy_o  <= 1'b1;
            req_o   <= 1'b1;
            we_o    <= 1'b1;
            addr_o  <= wr_addr(3'd0);
            wdata_o <= kernel_addr_i;
            state   <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (gnt_i) begin
            req_o <= 1'b0;
            state <= S_WR_RSP;
          end
        end

        S_WR_RSP: begin
          if (rvalid_i) begin
            if (idx != 3'd4) begin
              idx     <= idx + 3'd1;
              req_o   <= 1'b1;
              we_o    <= 1'b1;
              addr_o  <= wr_addr(idx + 3'd1);
              wdata_o <= wr_data(idx + 3'd1);
              state   <= S_WR_REQ;
            end else begin
              tcnt    <= 32'h0;
              req_o   <= 1'b1;
              we_o    <= 1'b0;
              addr_o  <= BASE_ADDR + 32'h20;
              wdata_o <= 32'h0;
              state   <= S_POLL_REQ;
            end
          end
        end

        S_POLL_REQ: begin
          // A grant in the same cycle as expiry wins; the read then completes.
          if (gnt_i) begin
            req_o <= 1'b0;
            state <= S_POLL_RSP;
          end else if (timed_out) begin
            req_o     <= 1'b0;
            timeout_o <= 1'b1;
            state     <= S_ABORT;
          end
        end

        S_POLL_RSP: begin
          if (rvalid_i) begin
            if (rdata_i == 32'h1) begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end else if (timed_out) begin
              timeout_o <= 1'b1;
              state     <= S_ABORT;
            end else if (POLL_GAP == 0) begin
              req_o <= 1'b1;
              state <= S_POLL_REQ;
            end else begin
              gap   <= POLL_GAP;
              state <= S_POLL_WAIT;
            end
          end
        end

        S_POLL_WAIT: begin
          if (timed_out) begin
            timeout_o <= 1'b1;
            state     <= S_ABORT;
          end else begin
            gap <= gap - 32'h1;
            if (gap <= 32'h1) begin
              req_o <= 1'b1;
              state <= S_POLL_REQ;
            end
          end
        end

        S_DONE, S_ABORT: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
